hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Next-generation hazard unit for the 5-stage RISC-V pipeline, adding a multi-cycle MDU (mul/div).
//  - EX-stage operand forwarding from M/W.
//  - Load-use stall with x0 excluded.
//  - Branch flush.
//  - Per-register pending-write scoreboard plus an MDU latency counter; stalls F/D on RAW/WAW/structural MDU hazards.
// PARAMETERS
//  REG_AW   5   register-address width; NREG = 1<<REG_AW scoreboard entries
//  MDU_LAT  4   MDU latency in cycles from issue to done; legal range 2..15
//  CNT_W    32  perf-counter width (HAZ_PERF_CNT_EN only)
// PORTS
//  clk            in   1       clock, rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  rs_1_d,rs_2_d  in   REG_AW  D-stage source regs
//  rd_d           in   REG_AW  D-stage dest reg
//  reg_write_d    in   1       D-stage instruction writes rd_d
//  mdu_op_d       in   1       D-stage instruction is an MDU op
//  rs_1_exe,rs_2_exe,rd_exe  in  REG_AW  EX-stage regs
//  result_src_exe in   1       EX instruction is a load
//  pc_src_exe     in   1       taken branch/jump resolved in EX
//  mdu_issue_exe  in   1       MDU op in EX is issuing this cycle (dest = rd_exe)
//  rd_m,rd_w      in   REG_AW  M/W dest regs
//  reg_write_m,reg_write_w  in  1  M/W write enables
//  stall_f,stall_d           out  1  hold PC / hold IF-ID
//  flush_d,flush_exe         out  1  bubble IF-ID / ID-EX
//  ForwardAE,ForwardBE       out  2  00 regfile, 01 W, 10 M
//  mdu_busy       out  1       MDU op in flight
//  mdu_done       out  1       MDU result writes regfile this cycle
//  mdu_rd_done    out  REG_AW  dest reg of completing MDU op
//  stall_cycles,flush_cycles out CNT_W  perf counters
// BEHAVIOUR
//  Reset (async, reset_n=0):
//    - pending[]=0, busy=0, cnt=0, counters=0.
//    - All outputs 0 once combinational terms settle; stall/flush forced 0 while reset_n=0.
//  Forwarding (combinational):
//    - Per operand: M match (reg_write_m, rs!=0) -> 10; else W match -> 01; else 00.
//    - M beats W.
//  Hazard terms (combinational, each excludes source/dest x0):
//    - lw_hz  = result_src_exe & rd_exe!=0 & (rd_exe==rs_1_d | rd_exe==rs_2_d).
//    - iss_hz = mdu_issue_exe & rd_exe!=0 & (rd_exe matches rs_1_d, rs_2_d, or rd_d when reg_write_d).
//    - sb_hz  = pending[rs_1_d] | pending[rs_2_d] | (reg_write_d & pending[rd_d]);
//               held through the done cycle (regfile written at that edge).
//    - st_hz  = mdu_op_d & (busy | mdu_issue_exe).
//    - haz    = lw_hz | iss_hz | sb_hz | st_hz.
//  Outputs:
//    - stall_f = stall_d = haz & ~pc_src_exe.
//    - flush_d = pc_src_exe.
//    - flush_exe = pc_src_exe | (haz & ~pc_src_exe).
//    - Branch flush wins over any stall, because the D instruction is wrong-path.
//  MDU tracker (sequential):
//    - Issue edge: pending[rd_exe]<=1 if rd_exe!=0; rd_q<=rd_exe; cnt<=MDU_LAT-1; busy<=1.
//    - While busy & cnt!=0: cnt decrements each cycle.
//    - mdu_done = busy & cnt==0; mdu_rd_done = rd_q (0 when idle).
//    - Done edge: pending[rd_q]<=0; busy<=0. Done falls exactly MDU_LAT cycles after the issue edge.
//    - Issue while busy cannot occur (st_hz); if driven anyway, the new issue is ignored.
//    - pc_src_exe & mdu_issue_exe are mutually exclusive by construction.
//    - An in-flight MDU op is never killed by a flush.
//    - reset_n low mid-operation aborts the op immediately; pending is cleared.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined:
//    - stall_cycles increments on each cycle with stall_d=1.
//    - flush_cycles increments on each cycle with flush_d=1.
//    - Both saturate at all-ones and never wrap.
//  HAZ_PERF_CNT_EN undefined: counters not built; both ports tied to 0.
// TESTING
//  - Fwd: rs_1_exe=5, rd_m=5, rd_w=5, both writes=1 -> ForwardAE=10. rs_2_exe=0, rd_w=0 -> ForwardBE=00.
//  - Load-use: result_src_exe=1, rd_exe=7, rs_2_d=7 -> stall_f=stall_d=flush_exe=1 for 1 cycle.
//    Same with rd_exe=0 -> no stall.
//  - MDU RAW, MDU_LAT=4: issue rd=9 at edge T; rs_1_d=9 from T+1 ->
//    - stall through T+4, mdu_done=1 in the cycle before T+4, mdu_rd_done=9;
//    - stall drops after T+4, pending[9]=0.
//  - Structural/WAW: mdu_op_d=1 while busy -> stall until done.
//    reg_write_d=1, rd_d=9 with pending[9] -> stall.
//  - Flush priority: pc_src_exe=1 with sb_hz=1 -> flush_d=flush_exe=1, stall_f=stall_d=0; MDU op completes unaffected.
//  - Reset mid-op: reset_n=0 at cnt=2 -> busy=0, mdu_done=0, pending=0 asynchronously.
//    With HAZ_PERF_CNT_EN: 3 stall cycles -> stall_cycles=3.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage RISC-V pipeline with a multi-cycle MDU scoreboard.
// Optional perf counters are built only when HAZ_PERF_CNT_EN is defined.
module hazard_scoreboard_unit #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] rs_1_d,
  input  logic [REG_AW-1:0] rs_2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              reg_write_d,
  input  logic              mdu_op_d,
  input  logic [REG_AW-1:0] rs_1_exe,
  input  logic [REG_AW-1:0] rs_2_exe,
  input  logic [REG_AW-1:0] rd_exe,
  input  logic              result_src_exe,
  input  logic              pc_src_exe,
  input  logic              mdu_issue_exe,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_exe,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [REG_AW-1:0] mdu_rd_done,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_cycles
);

  localparam int NREG = 1 << REG_AW;
  localparam logic [3:0] CNT_INIT = 4'(MDU_LAT - 1);

  logic [NREG-1:0]   pending_q, pending_d;
  logic              busy_q, busy_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] mdu_rd_q, mdu_rd_d;

  logic lw_hz, iss_hz, sb_hz, st_hz, haz;

  // Forwarding: one identical selector per EX operand, M has priority over W.
  logic [REG_AW-1:0] rs_exe [2];
  logic [1:0]        fwd    [2];
  assign rs_exe[0] = rs_1_exe;
  assign rs_exe[1] = rs_2_exe;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd[gi] = 2'b00;
        if (rs_exe[gi] != '0) begin
          if (reg_write_m && (rd_m == rs_exe[gi]))
            fwd[gi] = 2'b10;
          else if (reg_write_w && (rd_w == rs_exe[gi]))
            fwd[gi] = 2'b01;
        end
      end
    end
  endgenerate

  assign ForwardAE = fwd[0];
  assign ForwardBE = fwd[1];

  // pending_q[0] is never set, so x0 operands never hit the scoreboard.
  always_comb begin
    lw_hz  = result_src_exe && (rd_exe != '0) &&
             ((rd_exe == rs_1_d) || (rd_exe == rs_2_d));
    iss_hz = mdu_issue_exe && (rd_exe != '0) &&
             ((rd_exe == rs_1_d) || (rd_exe == rs_2_d) ||
              (reg_write_d && (rd_exe == rd_d)));
    sb_hz  = pending_q[rs_1_d] || pending_q[rs_2_d] ||
             (reg_write_d && pending_q[rd_d]);
    st_hz  = mdu_op_d && (busy_q || mdu_issue_exe);
    haz    = lw_hz || iss_hz || sb_hz || st_hz;
  end

  // A taken branch makes the D instruction wrong-path, so flush beats stall.
  assign stall_f   = reset_n && haz && !pc_src_exe;
  assign stall_d   = stall_f;
  assign flush_d   = reset_n && pc_src_exe;
  assign flush_exe = reset_n && (pc_src_exe || haz);

  // Tracker: a new issue is accepted only when idle; flushes never touch it.
  always_comb begin
    pending_d = pending_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    mdu_rd_d  = mdu_rd_q;
    if (busy_q) begin
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        busy_d              = 1'b0;
        pending_d[mdu_rd_q] = 1'b0;
      end
    end else if (mdu_issue_exe) begin
      busy_d   = 1'b1;
      cnt_d    = CNT_INIT;
      mdu_rd_d = rd_exe;
      if (rd_exe != '0)
        pending_d[rd_exe] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= 4'd0;
      mdu_rd_q  <= '0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      mdu_rd_q  <= mdu_rd_d;
    end
  end

  assign mdu_busy    = busy_q;
  assign mdu_done    = busy_q && (cnt_q == 4'd0);
  assign mdu_rd_done = busy_q ? mdu_rd_q : '0;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_d && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit (default MDU_LAT=4).
// Expected per-cycle outputs are queued when stimulus is applied and checked mid-cycle.
module tb_hazard_scoreboard_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  rs_1_d, rs_2_d, rd_d, rs_1_exe, rs_2_exe, rd_exe, rd_m, rd_w;
  logic        reg_write_d, mdu_op_d, result_src_exe, pc_src_exe, mdu_issue_exe;
  logic        reg_write_m, reg_write_w;
  logic        stall_f, stall_d, flush_d, flush_exe, mdu_busy, mdu_done;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [4:0]  mdu_rd_done;
  logic [31:0] stall_cycles, flush_cycles;

  hazard_scoreboard_unit dut (
    .clk(clk), .reset_n(reset_n),
    .rs_1_d(rs_1_d), .rs_2_d(rs_2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .mdu_op_d(mdu_op_d),
    .rs_1_exe(rs_1_exe), .rs_2_exe(rs_2_exe), .rd_exe(rd_exe),
    .result_src_exe(result_src_exe), .pc_src_exe(pc_src_exe),
    .mdu_issue_exe(mdu_issue_exe),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_exe(flush_exe),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .mdu_rd_done(mdu_rd_done),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       stall;
    logic       fl_d;
    logic       fl_e;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
    logic       done;
    logic [4:0] rdd;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] stall_acc = '0;
  logic [31:0] flush_acc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic st, input logic fd, input logic fe,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic busy, input logic done, input logic [4:0] rdd);
    exp_t e;
    e.stall = st; e.fl_d = fd; e.fl_e = fe; e.fa = fa; e.fb = fb;
    e.busy = busy; e.done = done; e.rdd = rdd;
    return e;
  endfunction

  // Queue the expectation, check it at the falling edge, return just after the next rising edge.
  task automatic sample(input string tag, input exp_t e);
    exp_t got;
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    check({tag, ".stall_f"},   32'(stall_f),     32'(got.stall));
    check({tag, ".stall_d"},   32'(stall_d),     32'(got.stall));
    check({tag, ".flush_d"},   32'(flush_d),     32'(got.fl_d));
    check({tag, ".flush_exe"}, 32'(flush_exe),   32'(got.fl_e));
    check({tag, ".fwd_a"},     32'(ForwardAE),   32'(got.fa));
    check({tag, ".fwd_b"},     32'(ForwardBE),   32'(got.fb));
    check({tag, ".busy"},      32'(mdu_busy),    32'(got.busy));
    check({tag, ".done"},      32'(mdu_done),    32'(got.done));
    check({tag, ".rd_done"},   32'(mdu_rd_done), 32'(got.rdd));
`ifdef HAZ_PERF_CNT_EN
    check({tag, ".stall_cyc"}, stall_cycles, stall_acc);
    check({tag, ".flush_cyc"}, flush_cycles, flush_acc);
    if (got.stall) stall_acc++;
    if (got.fl_d)  flush_acc++;
`else
    check({tag, ".stall_cyc"}, stall_cycles, 32'd0);
    check({tag, ".flush_cyc"}, flush_cycles, 32'd0);
`endif
    $display("txn %-14s stall=%0b fl_d=%0b fl_e=%0b fa=%0b fb=%0b busy=%0b done=%0b rd=%0d",
             tag, stall_f, flush_d, flush_exe, ForwardAE, ForwardBE, mdu_busy, mdu_done, mdu_rd_done);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs_1_d = '0; rs_2_d = '0; rd_d = '0; reg_write_d = 1'b0; mdu_op_d = 1'b0;
    rs_1_exe = '0; rs_2_exe = '0; rd_exe = '0; result_src_exe = 1'b0;
    pc_src_exe = 1'b0; mdu_issue_exe = 1'b0;
    rd_m = '0; rd_w = '0; reg_write_m = 1'b0; reg_write_w = 1'b0;
  endtask

  // Drain cycles 1..5 of an MDU op issued with nothing else going on.
  task automatic drain(input string tag, input logic [4:0] rd);
    clr();
    for (int i = 1; i <= 3; i++) sample(tag, mk(0, 0, 0, 0, 0, 1, 0, rd));
    sample({tag, "_done"}, mk(0, 0, 0, 0, 0, 1, 1, rd));
    sample({tag, "_idle"}, mk(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    clr();
    @(posedge clk); #1;
    sample("rst", mk(0, 0, 0, 0, 0, 0, 0, 0));
    pc_src_exe = 1'b1; result_src_exe = 1'b1; rd_exe = 5'd7; rs_2_d = 5'd7;
    sample("rst_force", mk(0, 0, 0, 0, 0, 0, 0, 0));
    clr();
    reset_n = 1'b1;

    // Forwarding
    rs_1_exe = 5'd5; rd_m = 5'd5; rd_w = 5'd5; reg_write_m = 1'b1; reg_write_w = 1'b1;
    sample("fwd_m_beats_w", mk(0, 0, 0, 2'b10, 2'b00, 0, 0, 0));
    rs_2_exe = 5'd6; rd_w = 5'd6;
    sample("fwd_w", mk(0, 0, 0, 2'b10, 2'b01, 0, 0, 0));
    reg_write_m = 1'b0; rs_2_exe = 5'd5; rs_1_exe = 5'd6;
    sample("fwd_no_wr_m", mk(0, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    reg_write_m = 1'b1; rd_m = 5'd0; rd_w = 5'd0; rs_1_exe = 5'd0; rs_2_exe = 5'd0;
    sample("fwd_x0", mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0));

    // Load-use
    clr(); result_src_exe = 1'b1; rd_exe = 5'd7; rs_2_d = 5'd7;
    sample("lu_rs2", mk(1, 0, 1, 0, 0, 0, 0, 0));
    clr(); rs_2_d = 5'd7;
    sample("lu_clear", mk(0, 0, 0, 0, 0, 0, 0, 0));
    result_src_exe = 1'b1; rd_exe = 5'd3; rs_1_d = 5'd3;
    sample("lu_rs1", mk(1, 0, 1, 0, 0, 0, 0, 0));
    clr(); result_src_exe = 1'b1; rd_exe = 5'd0; rs_1_d = 5'd0; rs_2_d = 5'd7;
    sample("lu_x0", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // MDU RAW on rs_1_d
    clr(); mdu_issue_exe = 1'b1; rd_exe = 5'd9;
    sample("raw_issue", mk(0, 0, 0, 0, 0, 0, 0, 0));
    clr(); rs_1_d = 5'd9;
    for (int i = 1; i <= 3; i++) sample("raw_wait", mk(1, 0, 1, 0, 0, 1, 0, 9));
    sample("raw_done", mk(1, 0, 1, 0, 0, 1, 1, 9));
    sample("raw_release", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Issue-cycle RAW against rs_2_d
    clr(); mdu_issue_exe = 1'b1; rd_exe = 5'd4; rs_2_d = 5'd4;
    sample("iss_hz", mk(1, 0, 1, 0, 0, 0, 0, 0));
    drain("iss_drain", 5'd4);

    // Structural and WAW
    clr(); mdu_issue_exe = 1'b1; rd_exe = 5'd9; mdu_op_d = 1'b1;
    sample("st_issue", mk(1, 0, 1, 0, 0, 0, 0, 0));
    clr(); mdu_op_d = 1'b1;
    sample("st_busy", mk(1, 0, 1, 0, 0, 1, 0, 9));
    clr(); reg_write_d = 1'b1; rd_d = 5'd9;
    sample("waw", mk(1, 0, 1, 0, 0, 1, 0, 9));
    clr(); rd_d = 5'd9; rs_1_d = 5'd3;
    sample("no_haz_busy", mk(0, 0, 0, 0, 0, 1, 0, 9));
    clr(); mdu_op_d = 1'b1;
    sample("st_done", mk(1, 0, 1, 0, 0, 1, 1, 9));
    sample("st_free", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Branch flush beats scoreboard stall; MDU op survives
    clr(); mdu_issue_exe = 1'b1; rd_exe = 5'd12;
    sample("fl_issue", mk(0, 0, 0, 0, 0, 0, 0, 0));
    clr(); rs_1_d = 5'd12; pc_src_exe = 1'b1;
    sample("fl_prio", mk(0, 1, 1, 0, 0, 1, 0, 12));
    clr();
    sample("fl_after", mk(0, 0, 0, 0, 0, 1, 0, 12));
    sample("fl_after", mk(0, 0, 0, 0, 0, 1, 0, 12));
    sample("fl_done", mk(0, 0, 0, 0, 0, 1, 1, 12));
    sample("fl_idle", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Issue while busy is ignored
    clr(); mdu_issue_exe = 1'b1; rd_exe = 5'd10;
    sample("ib_issue", mk(0, 0, 0, 0, 0, 0, 0, 0));
    rd_exe = 5'd11;
    sample("ib_second", mk(0, 0, 0, 0, 0, 1, 0, 10));
    clr();
    sample("ib_wait", mk(0, 0, 0, 0, 0, 1, 0, 10));
    sample("ib_wait", mk(0, 0, 0, 0, 0, 1, 0, 10));
    sample("ib_done", mk(0, 0, 0, 0, 0, 1, 1, 10));
    rs_1_d = 5'd11; rs_2_d = 5'd10;
    sample("ib_no_pend", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset mid-operation
    clr(); mdu_issue_exe = 1'b1; rd_exe = 5'd13;
    sample("rm_issue", mk(0, 0, 0, 0, 0, 0, 0, 0));
    clr(); rs_1_d = 5'd13;
    sample("rm_wait", mk(1, 0, 1, 0, 0, 1, 0, 13));
    reset_n = 1'b0;
    stall_acc = '0;
    flush_acc = '0;
    sample("rm_reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b1;
    sample("rm_cleared", mk(0, 0, 0, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
